// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: ISA opcodes, access-size codes,
// FSM state encoding, NOP instruction and opcode classification helpers.
package mem_stage_pkg;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_JR   = 6'h12;
  localparam logic [5:0] OP_JALR = 6'h13;
  localparam logic [5:0] OP_NOP  = 6'h15;
  localparam logic [5:0] OP_LH   = 6'h21;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SH   = 6'h29;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_LD   = 6'h37;
  localparam logic [5:0] OP_HALT = 6'h3E;
  localparam logic [5:0] OP_SD   = 6'h3F;

  localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'h0};

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return op inside {OP_SW, OP_SH, OP_SD};
  endfunction

  function automatic logic is_half_op(input logic [5:0] op);
    return op inside {OP_LH, OP_SH};
  endfunction

  function automatic logic is_dbl_op(input logic [5:0] op);
    return op inside {OP_LD, OP_SD};
  endfunction

endpackage

// File: rtl/mem_stage_ldfmt.sv
// mem_ldfmt: combinational load sign-extension and store-data formatting
// for word and halfword accesses.
module mem_ldfmt #(
  parameter int WIDTH = 32
) (
  input  logic             i_half,
  input  logic [WIDTH-1:0] i_rdata,
  input  logic [WIDTH-1:0] i_sd,
  output logic [WIDTH-1:0] o_load,
  output logic [WIDTH-1:0] o_wdata
);

  assign o_load  = i_half ? {{(WIDTH-16){i_rdata[15]}}, i_rdata[15:0]} : i_rdata;
  assign o_wdata = i_half ? {{(WIDTH-16){1'b0}}, i_sd[15:0]} : i_sd;

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through and runs one- or two-beat
// load/store transactions. Optional alignment trap: MEM_ALIGN_CHECK_EN.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = `WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] SD_lo,
  input  logic [WIDTH-1:0] SD_hi,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic [WIDTH-1:0] LMD,
  output logic [WIDTH-1:0] LMD_hi,
  output logic             IsStall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [1:0]       mem_size,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             MemFault,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ir, r_z, r_sd_lo, r_sd_hi, r_addr;
  logic [WIDTH-3:0] r_pc;
  logic             r_store, r_half, r_dbl;

  logic [5:0]       w_op;
  logic             w_accept, w_mem_op, w_misalign, w_issue, w_busy, w_last;
  logic [WIDTH-1:0] w_addr_in, w_load, w_wdata, w_sd;

  assign w_op      = IR_in[31:26];
  assign w_accept  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_mem_op  = is_mem_op(w_op);
  assign w_addr_in = is_half_op(w_op) ? {Z_in[WIDTH-1:1], 1'b0}
                                      : {Z_in[WIDTH-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
  logic r_fault;
  assign w_misalign = is_half_op(w_op) ? Z_in[0] : (Z_in[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) r_fault <= 1'b0;
    else     r_fault <= w_accept && w_mem_op && w_misalign;
  end
  assign MemFault = r_fault;
`else
  assign w_misalign = 1'b0;
  assign MemFault   = 1'b0;
`endif

  assign w_issue = w_accept && w_mem_op && !w_misalign;
  assign w_busy  = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);
  assign w_last  = (r_state == ST_BEAT1) || ((r_state == ST_BEAT0) && !r_dbl);
  assign w_sd    = (r_state == ST_BEAT1) ? r_sd_hi : r_sd_lo;

  mem_ldfmt #(.WIDTH(WIDTH)) u_ldfmt (
    .i_half  (r_half),
    .i_rdata (mem_rdata),
    .i_sd    (w_sd),
    .o_load  (w_load),
    .o_wdata (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: w_next = w_issue ? ST_BEAT0 : ST_IDLE;
      ST_BEAT0:         if (mem_ack) w_next = r_dbl ? ST_BEAT1 : ST_DONE;
      ST_BEAT1:         if (mem_ack) w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Handshake: upstream advances after any edge where IsStall was low. Stall
  // drops in the final ack cycle so the next instruction lands in DONE.
  always_comb begin
    mem_req     = w_busy;
    mem_we      = w_busy && r_store;
    mem_size    = (w_busy && r_half) ? SIZE_HALF : SIZE_WORD;
    mem_addr    = (r_state == ST_BEAT1) ? r_addr + WIDTH'(4) : r_addr;
    mem_wdata   = w_wdata;
    IsStall     = w_issue || (w_busy && !(mem_ack && w_last));
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IR_out  <= WIDTH'(NOP_INSTR);
      PC_out  <= '0;
      Z_out   <= '0;
      LMD     <= '0;
      LMD_hi  <= '0;
      r_ir    <= '0;
      r_pc    <= '0;
      r_z     <= '0;
      r_sd_lo <= '0;
      r_sd_hi <= '0;
      r_addr  <= '0;
      r_store <= 1'b0;
      r_half  <= 1'b0;
      r_dbl   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_issue) begin
            r_ir    <= IR_in;
            r_pc    <= PC_in;
            r_z     <= Z_in;
            r_sd_lo <= SD_lo;
            r_sd_hi <= SD_hi;
            r_addr  <= w_addr_in;
            r_store <= is_store_op(w_op);
            r_half  <= is_half_op(w_op);
            r_dbl   <= is_dbl_op(w_op);
            IR_out  <= WIDTH'(NOP_INSTR);
          end else if (w_mem_op) begin
            IR_out  <= WIDTH'(NOP_INSTR);
          end else begin
            IR_out  <= IR_in;
            PC_out  <= PC_in;
            Z_out   <= Z_in;
          end
        end
        ST_BEAT0: begin
          if (mem_ack) begin
            if (!r_store) LMD <= w_load;
            if (!r_dbl) begin
              IR_out <= r_ir;
              PC_out <= r_pc;
              Z_out  <= r_z;
            end
          end
        end
        ST_BEAT1: begin
          if (mem_ack) begin
            if (!r_store) LMD_hi <= mem_rdata;
            IR_out <= r_ir;
            PC_out <= r_pc;
            Z_out  <= r_z;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: randomized instruction stream against a
// transaction-level reference model, plus directed corner cases.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct packed {
    logic [31:0] ir;
    logic [29:0] pc;
    logic [31:0] z;
    logic [31:0] lmd;
    logic [31:0] lmd_hi;
    logic [31:0] cyc;
  } ret_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        chk_wd;
  } acc_t;

  typedef struct packed {
    logic [7:0]  waits;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IR_in, Z_in, SD_lo, SD_hi, mem_rdata;
  logic [29:0] PC_in;
  logic        mem_ack;
  logic [31:0] IR_out, Z_out, LMD, LMD_hi, mem_addr, mem_wdata;
  logic [29:0] PC_out;
  logic        IsStall, mem_req, mem_we, MemFault;
  logic [1:0]  mem_size, dbg_state;

  mem_stage dut (
    .clk(clk), .rst(rst), .IR_in(IR_in), .PC_in(PC_in), .Z_in(Z_in),
    .SD_lo(SD_lo), .SD_hi(SD_hi), .IR_out(IR_out), .PC_out(PC_out),
    .Z_out(Z_out), .LMD(LMD), .LMD_hi(LMD_hi), .IsStall(IsStall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .MemFault(MemFault), .o_dbg_state(dbg_state)
  );

  ret_t exp_q[$];
  acc_t mem_q[$];
  rsp_t rsp_q[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fault_exp = 0;
  int          fault_seen = 0;
  int          fix_wait = -1;
  bit          fix_data_en = 1'b0;
  logic [31:0] fix_data = '0;
  bit          manual = 1'b0;
  logic [31:0] mdl_lmd = '0;
  logic [31:0] mdl_lmd_hi = '0;
  logic [5:0]  op_tab [12] = '{OP_ALU, OP_ADDI, OP_J, OP_BEQZ, OP_HALT, 6'h3A,
                               OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    logic [31:0] r;
    r = $urandom;
    return {op, r[25:0]};
  endfunction

  // ---------------- driver + reference model ----------------
  task automatic send(input logic [31:0] ir, input logic [29:0] pc, input logic [31:0] z,
                      input logic [31:0] lo, input logic [31:0] hi);
    logic [5:0]  op;
    bit          mem, st, hf, db, flt, busy;
    int          nb, tw, w, n, stall_n, stall_exp;
    logic [31:0] base, d;
    ret_t        r;
    acc_t        a;
    op  = ir[31:26];
    mem = op inside {OP_LW, OP_LH, OP_LD, OP_SW, OP_SH, OP_SD};
    st  = op inside {OP_SW, OP_SH, OP_SD};
    hf  = op inside {OP_LH, OP_SH};
    db  = op inside {OP_LD, OP_SD};
    flt = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (mem) flt = hf ? z[0] : (z[1:0] != 2'b00);
`endif
    stall_exp = 0;
    tw = 0;
    nb = 0;
    if (flt) begin
      fault_exp++;
    end else begin
      if (mem) begin
        nb   = db ? 2 : 1;
        base = hf ? (z & ~32'h1) : (z & ~32'h3);
        for (int b = 0; b < nb; b++) begin
          w = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
          d = fix_data_en ? fix_data : $urandom;
          rsp_q.push_back({8'(w), d});
          tw += w;
          a.addr   = base + 32'(4 * b);
          a.we     = st;
          a.wdata  = (b == 1) ? hi : (hf ? (lo & 32'h0000_FFFF) : lo);
          a.size   = hf ? 2'b01 : 2'b00;
          a.chk_wd = st;
          mem_q.push_back(a);
          if (!st) begin
            if (b == 1)  mdl_lmd_hi = d;
            else if (hf) mdl_lmd = d[15] ? 32'(d[15:0]) - 32'h0001_0000 : 32'(d[15:0]);
            else         mdl_lmd = d;
          end
        end
        stall_exp = tw + nb;
      end
      r.ir = ir; r.pc = pc; r.z = z; r.lmd = mdl_lmd; r.lmd_hi = mdl_lmd_hi;
      r.cyc = 32'(cyc + 1 + tw + nb);
      exp_q.push_back(r);
    end
    IR_in = ir; PC_in = pc; Z_in = z; SD_lo = lo; SD_hi = hi;
    n = 0;
    stall_n = 0;
    do begin
      @(negedge clk);
      busy = IsStall;
      if (busy) stall_n++;
      n++;
      @(posedge clk);
      #1;
    end while (busy && n < 64);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: IsStall still high after %0d cycles, op %0h", n, op);
    end
    check("stall_cycles", 64'(stall_n), 64'(stall_exp));
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bit          rbusy;
    int          wl;
    logic [31:0] cur;
    rsp_t        rs;
    mem_ack = 1'b0;
    mem_rdata = '0;
    rbusy = 1'b0;
    wl = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!manual) begin
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
          if (!rbusy) begin
            if (rsp_q.size() > 0) begin
              rs = rsp_q.pop_front();
              wl = int'(rs.waits);
              cur = rs.data;
            end else begin
              wl = 0;
              cur = $urandom;
            end
            rbusy = 1'b1;
          end
          if (wl == 0) begin
            mem_ack = 1'b1;
            mem_rdata = cur;
            rbusy = 1'b0;
          end else begin
            wl--;
            mem_rdata = $urandom;
          end
        end else begin
          rbusy = 1'b0;
        end
      end else begin
        rbusy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  ret_t m_r;
  acc_t m_a;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (IR_out != NOP_INSTR) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: IR_out %0h with nothing expected", IR_out);
        end else begin
          m_r = exp_q.pop_front();
          check("ir_out", 64'(IR_out), 64'(m_r.ir));
          check("pc_out", 64'(PC_out), 64'(m_r.pc));
          check("z_out", 64'(Z_out), 64'(m_r.z));
          check("lmd", 64'(LMD), 64'(m_r.lmd));
          check("lmd_hi", 64'(LMD_hi), 64'(m_r.lmd_hi));
          check("retire_cycle", 64'(cyc), 64'(m_r.cyc));
        end
      end
      if (mem_req && mem_ack) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL access_unexpected: addr %0h we %0b", mem_addr, mem_we);
        end else begin
          m_a = mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(m_a.addr));
          check("mem_we", 64'(mem_we), 64'(m_a.we));
          check("mem_size", 64'(mem_size), 64'(m_a.size));
          if (m_a.chk_wd) check("mem_wdata", 64'(mem_wdata), 64'(m_a.wdata));
        end
      end
      if (MemFault) fault_seen++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0]  op;
    logic [31:0] z;
    rst = 1'b1;
    IR_in = NOP_INSTR; PC_in = '0; Z_in = '0; SD_lo = '0; SD_hi = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ir_out", 64'(IR_out), 64'(NOP_INSTR));
    check("rst_pc_out", 64'(PC_out), 64'h0);
    check("rst_z_out", 64'(Z_out), 64'h0);
    check("rst_lmd", 64'(LMD), 64'h0);
    check("rst_lmd_hi", 64'(LMD_hi), 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_isstall", 64'(IsStall), 64'h0);
    check("rst_memfault", 64'(MemFault), 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed corner cases
    fix_wait = 3; fix_data_en = 1'b1; fix_data = 32'hDEAD_BEEF;
    send(mk(OP_LW), 30'd1, 32'h0000_0100, 32'h0, 32'h0);
    fix_wait = 0; fix_data = 32'h0000_8001;
    send(mk(OP_LH), 30'd2, 32'h0000_0104, 32'h0, 32'h0);
    send(mk(OP_SH), 30'd3, 32'h0000_0108, 32'h1234_5678, 32'h0);
    send(mk(OP_SD), 30'd4, 32'h0000_0200, 32'h11, 32'h22);
    fix_data_en = 1'b0;
    send(mk(OP_LD), 30'd5, 32'hFFFF_FFFC, 32'h0, 32'h0);
    send(mk(OP_ALU), 30'd6, 32'h0000_1234, 32'h0, 32'h0);
    send(mk(OP_LW), 30'd7, 32'h0000_0300, 32'h0, 32'h0);
    send(mk(OP_LW), 30'd8, 32'h0000_0102, 32'h0, 32'h0);
    send(mk(6'h3A), 30'd9, 32'h0000_0055, 32'h0, 32'h0);
    fix_wait = -1;

    // reset in BEAT1 of an LD, late ack must be ignored
    manual = 1'b1;
    mem_ack = 1'b0;
    IR_in = mk(OP_LD); PC_in = 30'd10; Z_in = 32'h0000_0300;
    @(posedge clk); #1;
    IR_in = NOP_INSTR;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    m_a.addr = 32'h0000_0300; m_a.we = 1'b0; m_a.wdata = '0; m_a.size = 2'b00; m_a.chk_wd = 1'b0;
    mem_q.push_back(m_a);
    @(posedge clk); #1;
    mem_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    mdl_lmd = '0; mdl_lmd_hi = '0;
    @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("midrst_mem_req", 64'(mem_req), 64'h0);
    check("midrst_lmd", 64'(LMD), 64'h0);
    check("midrst_lmd_hi", 64'(LMD_hi), 64'h0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_state", 64'(dbg_state), 64'(ST_IDLE));
    check("late_ack_mem_req", 64'(mem_req), 64'h0);
    check("late_ack_lmd_hi", 64'(LMD_hi), 64'h0);
    @(posedge clk); #1;
    manual = 1'b0;

    // randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      op = op_tab[$urandom_range(0, 11)];
      z = $urandom;
      if ($urandom_range(0, 3) != 0) z[1:0] = 2'b00;
      send(mk(op), 30'($urandom), z, $urandom, $urandom);
    end

    IR_in = NOP_INSTR;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("retire_q_drained", 64'(exp_q.size()), 64'h0);
    check("access_q_drained", 64'(mem_q.size()), 64'h0);
    check("resp_q_drained", 64'(rsp_q.size()), 64'h0);
    check("memfault_cycles", 64'(fault_seen), 64'(fault_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
